// File: rtl/logic_eval_arbiter.sv
// Four-way round-robin arbiter in front of one shared E/F logic evaluator.
// A granted operand nibble is evaluated over EVAL_CYCLES cycles; the result is held until the consumer accepts it.
module logic_eval_arbiter #(
  parameter int EVAL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] req_data,
  output logic [3:0]  gnt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic        rsp_e,
  output logic        rsp_f,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_RESP
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(EVAL_CYCLES - 1);

  state_t      r_state;
  state_t      w_stateNext;

  logic [1:0]  r_ptr;
  logic [1:0]  r_cnt;
  logic [3:0]  r_nib;
  logic [3:0]  r_gnt;
  logic        r_rspValid;
  logic [1:0]  r_rspId;
  logic        r_rspE;
  logic        r_rspF;
  logic [7:0]  r_opCount;

  logic        w_found;
  logic [1:0]  w_winner;
  logic [1:0]  w_idx;
  logic [3:0]  w_reqNib;
  logic        w_accept;
  logic        w_evalDone;
  logic        w_cntDec;
  logic        w_handshake;
  logic        w_a;
  logic        w_b;
  logic        w_c;
  logic        w_d;
  logic        w_eNext;
  logic        w_fNext;

  // Scan downward from ptr+3 to ptr so the requester closest to ptr wins last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_reqNib = req_data[{w_winner, 2'b00} +: 4];

  assign w_a     = r_nib[3];
  assign w_b     = r_nib[2];
  assign w_c     = r_nib[1];
  assign w_d     = r_nib[0];
  assign w_eNext = ~w_a | (w_a & w_b) | w_c;
  assign w_fNext = ~(((w_a & w_b) | w_c) & w_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_evalDone  = 1'b0;
    w_cntDec    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_stateNext = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (r_cnt == 2'd0) begin
          w_evalDone  = 1'b1;
          w_stateNext = ST_RESP;
        end else begin
          w_cntDec = 1'b1;
        end
      end
      ST_RESP: begin
        if (r_rspValid && rsp_ready) begin
          w_handshake = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // The operand is captured at acceptance so later req_data changes cannot disturb the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 2'd0;
      r_cnt      <= 2'd0;
      r_nib      <= 4'd0;
      r_gnt      <= 4'd0;
      r_rspValid <= 1'b0;
      r_rspId    <= 2'd0;
      r_rspE     <= 1'b0;
      r_rspF     <= 1'b0;
      r_opCount  <= 8'd0;
    end else begin
      r_gnt <= 4'd0;
      if (w_accept) begin
        r_gnt   <= 4'b0001 << w_winner;
        r_nib   <= w_reqNib;
        r_rspId <= w_winner;
        r_ptr   <= w_winner + 2'd1;
        r_cnt   <= CNT_LOAD;
      end
      if (w_cntDec) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_evalDone) begin
        r_rspE     <= w_eNext;
        r_rspF     <= w_fNext;
        r_rspValid <= 1'b1;
      end
      if (w_handshake) begin
        r_rspValid <= 1'b0;
        r_opCount  <= r_opCount + 8'd1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_e     = r_rspE;
  assign rsp_f     = r_rspF;
  assign busy      = (r_state != ST_IDLE);
  assign op_count  = r_opCount;

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Bench for logic_eval_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_logic_eval_arbiter;

  localparam int EC = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_e;
  logic        rsp_f;
  logic        busy;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;

  // Reference model: phase flags and an "edges until result" count.
  bit         mInEval;
  bit         mResp;
  int         mEvalLeft;
  int         mPtr;
  int         mHandshakes;
  logic [3:0] mNib;
  logic [3:0] expGnt;
  logic       expValid;
  logic [1:0] expId;
  logic       expE;
  logic       expF;
  logic       expBusy;
  int         expCount;

  logic [3:0] nibTab [4];
  logic       eTab [4];
  logic       fTab [4];

  logic_eval_arbiter #(.EVAL_CYCLES(EC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_e     (rsp_e),
    .rsp_f     (rsp_f),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advances the model by one clock edge given the inputs present at that edge.
  function automatic void modelStep(input logic r, input logic [3:0] rq, input logic [15:0] d, input logic rdy);
    int win;
    int a, b, c, dd;
    if (r) begin
      mInEval = 0; mResp = 0; mEvalLeft = 0; mPtr = 0; mNib = 4'd0;
      expGnt = 4'd0; expValid = 1'b0; expId = 2'd0; expE = 1'b0; expF = 1'b0;
      expBusy = 1'b0; expCount = 0;
      return;
    end
    expGnt = 4'd0;
    if (mInEval) begin
      mEvalLeft--;
      if (mEvalLeft == 0) begin
        a = int'(mNib[3]); b = int'(mNib[2]); c = int'(mNib[1]); dd = int'(mNib[0]);
        expE = ((a == 0) || (a == 1 && b == 1) || (c == 1)) ? 1'b1 : 1'b0;
        expF = ((((a == 1 && b == 1) || (c == 1)) && (dd == 1))) ? 1'b0 : 1'b1;
        expValid = 1'b1;
        mInEval = 0;
        mResp = 1;
      end
    end else if (mResp) begin
      if (rdy) begin
        expValid = 1'b0;
        expCount = (expCount + 1) % 256;
        mResp = 0;
        mHandshakes++;
      end
    end else if (rq != 4'd0) begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && rq[(mPtr + k) % 4]) win = (mPtr + k) % 4;
      end
      expGnt = 4'(1 << win);
      expId = 2'(win);
      mNib = 4'((d >> (4 * win)) & 16'hF);
      mPtr = (win + 1) % 4;
      mEvalLeft = EC;
      mInEval = 1;
    end
    expBusy = mInEval || mResp;
  endfunction

  task automatic compareAll();
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("op_count", 32'(op_count), 32'(expCount));
    if (expValid) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(expId));
      checkOutput("rsp_e", 32'(rsp_e), 32'(expE));
      checkOutput("rsp_f", 32'(rsp_f), 32'(expF));
    end
  endtask

  // Drives one cycle of inputs, steps the model, and compares after the edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [15:0] d, input logic rdy);
    rst = r; req = rq; req_data = d; rsp_ready = rdy;
    modelStep(r, rq, d, rdy);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 4'd0, 16'd0, 1'b0);
    applyStimulus(1'b1, 4'd0, 16'd0, 1'b0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_e", 32'(rsp_e), 32'd0);
    checkOutput("rst_f", 32'(rsp_f), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(op_count), 32'd0);
  endtask

  task automatic waitValid(input logic [3:0] rq, input logic rdy);
    for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) begin
      applyStimulus(1'b0, rq, 16'($urandom), rdy);
    end
    checkOutput("wait_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      applyStimulus(1'b0, 4'd0, 16'($urandom), 1'b1);
    end
  endtask

  initial begin
    int rrExp;
    bit seen255;
    logic [3:0] held;
    logic r;

    nibTab = '{4'h0, 4'h8, 4'hB, 4'h9};
    eTab   = '{1'b1, 1'b0, 1'b1, 1'b0};
    fTab   = '{1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; req = 4'd0; req_data = 16'd0; rsp_ready = 1'b0;
    mHandshakes = 0;

    doReset();

    // Single request on requester 0, nibble 1101.
    applyStimulus(1'b0, 4'b0001, 16'h000D, 1'b1);
    checkOutput("single_gnt", 32'(gnt), 32'h1);
    applyStimulus(1'b0, 4'b0000, 16'($urandom), 1'b1);
    checkOutput("single_early_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 4'b0000, 16'($urandom), 1'b1);
    checkOutput("single_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_id", 32'(rsp_id), 32'd0);
    checkOutput("single_e", 32'(rsp_e), 32'd1);
    checkOutput("single_f", 32'(rsp_f), 32'd0);
    applyStimulus(1'b0, 4'b0000, 16'($urandom), 1'b1);
    checkOutput("single_count", 32'(op_count), 32'd1);
    checkOutput("single_after_valid", 32'(rsp_valid), 32'd0);

    // Truth table sequence on requester 2.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b0100, {4'h0, nibTab[i], 8'h00}, 1'b0);
      waitValid(4'b0000, 1'b0);
      checkOutput("truth_id", 32'(rsp_id), 32'd2);
      checkOutput("truth_e", 32'(rsp_e), 32'(eTab[i]));
      checkOutput("truth_f", 32'(rsp_f), 32'(fTab[i]));
      applyStimulus(1'b0, 4'b0000, 16'($urandom), 1'b1);
    end

    // Fairness with all four requesting continuously.
    doReset();
    rrExp = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 4'hF, 16'($urandom), 1'b1);
      if (gnt != 4'd0) begin
        checkOutput("rr_order", 32'(gnt), 32'(1 << (rrExp % 4)));
        rrExp++;
      end
    end
    checkOutput("rr_grants", 32'(rrExp >= 8), 32'd1);

    // Backpressure: requester 1 with nibble 1011 -> E=1, F=0.
    doReset();
    applyStimulus(1'b0, 4'b0010, 16'h00B0, 1'b0);
    waitValid(4'b0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b1010, 16'($urandom), 1'b0);
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_e", 32'(rsp_e), 32'd1);
      checkOutput("bp_f", 32'(rsp_f), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_gnt", 32'(gnt), 32'd0);
    end
    applyStimulus(1'b0, 4'b1010, 16'($urandom), 1'b1);
    checkOutput("bp_done_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_done_busy", 32'(busy), 32'd0);
    checkOutput("bp_done_count", 32'(op_count), 32'd1);
    applyStimulus(1'b0, 4'b0000, 16'($urandom), 1'b1);
    checkOutput("bp_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of an evaluation.
    applyStimulus(1'b0, 4'b0010, 16'($urandom), 1'b1);
    applyStimulus(1'b0, 4'b0000, 16'($urandom), 1'b1);
    applyStimulus(1'b1, 4'b0001, 16'($urandom), 1'b1);
    checkOutput("mid_rst_gnt", 32'(gnt), 32'd0);
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_count", 32'(op_count), 32'd0);
    checkOutput("mid_rst_id", 32'(rsp_id), 32'd0);
    applyStimulus(1'b0, 4'b0011, 16'($urandom), 1'b1);
    checkOutput("mid_rst_next_gnt", 32'(gnt), 32'h1);
    drain(10);

    // op_count wraps after 256 completed handshakes.
    doReset();
    mHandshakes = 0;
    seen255 = 0;
    for (int c = 0; c < 1200 && mHandshakes < 256; c++) begin
      applyStimulus(1'b0, 4'hF, 16'($urandom), 1'b1);
      if (mHandshakes == 255 && !seen255) begin
        seen255 = 1;
        checkOutput("wrap_255", 32'(op_count), 32'd255);
      end
    end
    checkOutput("wrap_zero", 32'(op_count), 32'd0);
    checkOutput("wrap_ops", 32'(mHandshakes), 32'd256);

    // Randomized traffic: requesters hold until granted, may re-request right away.
    doReset();
    held = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (held[b] && expGnt[b]) held[b] = ($urandom_range(0, 99) < 40);
        else if (!held[b]) held[b] = ($urandom_range(0, 99) < 30);
      end
      r = ($urandom_range(0, 99) == 0);
      applyStimulus(r, held, 16'($urandom), ($urandom_range(0, 99) < 60));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
